// File: rtl/crc32_slice8_ctrl_pkg.sv
// Shared constants, state encoding and table generator for the slicing-by-8 CRC-32 block.
// No ports: imported by crctab_ev0..ev7, crc32_slice8_fold and crc32_slice8_ctrl.
package crc32_slice8_ctrl_pkg;

    localparam logic [31:0] CRC_POLY   = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT   = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_XOROUT = 32'hFFFFFFFF;
    localparam int          CNT_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_TAIL = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Table k of the slicing-by-8 set is the reflected CRC of byte idx followed by
    // k zero bytes, i.e. 8*(k+1) bit steps starting from idx.
    function automatic logic [31:0] crc_tab_entry(input int unsigned steps, input logic [7:0] idx);
        logic [31:0] c;
        c = {24'h0, idx};
        for (int unsigned i = 0; i < steps; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_slice8_fold.sv
// crctab_ev0..ev7: 256-entry CRC-32 lookup tables (addr_i -> data_o). Only addresses
//   0..255 are populated; any address with addr_i[31:8] != 0 reads as zero.
// crc32_slice8_fold: combinational fold datapath.
//   crc_i      running CRC
//   data_i     64-bit message word, byte0 in [7:0]
//   byte_i     next tail byte
//   word_crc_o CRC after folding all eight bytes of data_i
//   byte_crc_o CRC after folding byte_i alone through table 0
module crctab_ev0 import crc32_slice8_ctrl_pkg::*; (input logic [31:0] addr_i, output logic [31:0] data_o);
    assign data_o = (addr_i[31:8] == 24'h0) ? crc_tab_entry(8, addr_i[7:0]) : 32'h0;
endmodule

module crctab_ev1 import crc32_slice8_ctrl_pkg::*; (input logic [31:0] addr_i, output logic [31:0] data_o);
    assign data_o = (addr_i[31:8] == 24'h0) ? crc_tab_entry(16, addr_i[7:0]) : 32'h0;
endmodule

module crctab_ev2 import crc32_slice8_ctrl_pkg::*; (input logic [31:0] addr_i, output logic [31:0] data_o);
    assign data_o = (addr_i[31:8] == 24'h0) ? crc_tab_entry(24, addr_i[7:0]) : 32'h0;
endmodule

module crctab_ev3 import crc32_slice8_ctrl_pkg::*; (input logic [31:0] addr_i, output logic [31:0] data_o);
    assign data_o = (addr_i[31:8] == 24'h0) ? crc_tab_entry(32, addr_i[7:0]) : 32'h0;
endmodule

module crctab_ev4 import crc32_slice8_ctrl_pkg::*; (input logic [31:0] addr_i, output logic [31:0] data_o);
    assign data_o = (addr_i[31:8] == 24'h0) ? crc_tab_entry(40, addr_i[7:0]) : 32'h0;
endmodule

module crctab_ev5 import crc32_slice8_ctrl_pkg::*; (input logic [31:0] addr_i, output logic [31:0] data_o);
    assign data_o = (addr_i[31:8] == 24'h0) ? crc_tab_entry(48, addr_i[7:0]) : 32'h0;
endmodule

module crctab_ev6 import crc32_slice8_ctrl_pkg::*; (input logic [31:0] addr_i, output logic [31:0] data_o);
    assign data_o = (addr_i[31:8] == 24'h0) ? crc_tab_entry(56, addr_i[7:0]) : 32'h0;
endmodule

module crctab_ev7 import crc32_slice8_ctrl_pkg::*; (input logic [31:0] addr_i, output logic [31:0] data_o);
    assign data_o = (addr_i[31:8] == 24'h0) ? crc_tab_entry(64, addr_i[7:0]) : 32'h0;
endmodule

module crc32_slice8_fold (
    input  logic [31:0] crc_i,
    input  logic [63:0] data_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_crc_o,
    output logic [31:0] byte_crc_o
);
    logic [63:0] x;
    logic [31:0] t0, t1, t2, t3, t4, t5, t6, t7, tb;

    assign x = data_i ^ {32'h0, crc_i};

    // The first byte on the wire has the most bytes still to follow, so it uses the deepest table.
    crctab_ev7 u_t7 (.addr_i({24'h0, x[7:0]}),   .data_o(t7));
    crctab_ev6 u_t6 (.addr_i({24'h0, x[15:8]}),  .data_o(t6));
    crctab_ev5 u_t5 (.addr_i({24'h0, x[23:16]}), .data_o(t5));
    crctab_ev4 u_t4 (.addr_i({24'h0, x[31:24]}), .data_o(t4));
    crctab_ev3 u_t3 (.addr_i({24'h0, x[39:32]}), .data_o(t3));
    crctab_ev2 u_t2 (.addr_i({24'h0, x[47:40]}), .data_o(t2));
    crctab_ev1 u_t1 (.addr_i({24'h0, x[55:48]}), .data_o(t1));
    crctab_ev0 u_t0 (.addr_i({24'h0, x[63:56]}), .data_o(t0));

    // Separate table-0 port for the byte-serial tail so both paths read in the same cycle.
    crctab_ev0 u_tb (.addr_i({24'h0, crc_i[7:0] ^ byte_i}), .data_o(tb));

    assign word_crc_o = t7 ^ t6 ^ t5 ^ t4 ^ t3 ^ t2 ^ t1 ^ t0;
    assign byte_crc_o = tb ^ (crc_i >> 8);
endmodule

// File: rtl/crc32_slice8_ctrl.sv
// Slicing-by-8 CRC-32 sequencer: folds 64-bit words one per cycle, finishes a partial
// last word byte-serially, and presents the final CRC on a held valid/ready output.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   s_valid/s_ready          input word handshake
//   s_data[63:0]             message bytes, byte0 = s_data[7:0] first
//   s_last, s_nbytes[3:0]    end of message, valid low bytes in last word (0 or >8 means 8)
//   m_valid/m_ready          result handshake
//   m_crc[31:0]              final CRC, zero outside DONE
//   busy                     state is not IDLE
//
// state | meaning
// IDLE  | waiting for the first word of a message
// RUN   | mid-message, folding full words
// TAIL  | byte-serial fold of a partial last word
// DONE  | result held on m_crc until m_ready
module crc32_slice8_ctrl #(
    parameter logic [31:0] CRC_INIT   = crc32_slice8_ctrl_pkg::CRC_INIT,
    parameter logic [31:0] CRC_XOROUT = crc32_slice8_ctrl_pkg::CRC_XOROUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [63:0] s_data,
    input  logic        s_last,
    input  logic [3:0]  s_nbytes,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_crc,
    output logic        busy
);
    import crc32_slice8_ctrl_pkg::*;

    state_e           state_q;
    logic [31:0]      crc_q;
    logic [63:0]      tail_q;
    logic [CNT_W-1:0] cnt_q;
    logic             s_ready_q, m_valid_q, busy_q;
    logic [31:0]      m_crc_q;

    logic             xfer_d;
    logic [CNT_W-1:0] n_eff_d;
    logic [31:0]      word_crc, byte_crc;

    crc32_slice8_fold u_fold (
        .crc_i      (crc_q),
        .data_i     (s_data),
        .byte_i     (tail_q[7:0]),
        .word_crc_o (word_crc),
        .byte_crc_o (byte_crc)
    );

    assign xfer_d  = s_valid & s_ready_q;
    assign n_eff_d = ((s_nbytes == 4'd0) || (s_nbytes > 4'd8)) ? 4'd8 : s_nbytes;

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            crc_q     <= CRC_INIT;
            tail_q    <= 64'h0;
            cnt_q     <= '0;
            s_ready_q <= 1'b1;
            m_valid_q <= 1'b0;
            m_crc_q   <= 32'h0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_RUN: begin
                    if (xfer_d) begin
                        busy_q <= 1'b1;
                        if (!s_last) begin
                            crc_q   <= word_crc;
                            state_q <= ST_RUN;
                        end else if (n_eff_d == 4'd8) begin
                            crc_q     <= word_crc;
                            state_q   <= ST_DONE;
                            s_ready_q <= 1'b0;
                            m_valid_q <= 1'b1;
                            m_crc_q   <= word_crc ^ CRC_XOROUT;
                        end else begin
                            tail_q    <= s_data;
                            cnt_q     <= n_eff_d;
                            state_q   <= ST_TAIL;
                            s_ready_q <= 1'b0;
                        end
                    end
                end
                ST_TAIL: begin
                    crc_q  <= byte_crc;
                    tail_q <= tail_q >> 8;
                    cnt_q  <= cnt_q - 1'b1;
                    if (cnt_q == 4'd1) begin
                        state_q   <= ST_DONE;
                        m_valid_q <= 1'b1;
                        m_crc_q   <= byte_crc ^ CRC_XOROUT;
                    end
                end
                ST_DONE: begin
                    if (m_ready) begin
                        crc_q     <= CRC_INIT;
                        state_q   <= ST_IDLE;
                        s_ready_q <= 1'b1;
                        m_valid_q <= 1'b0;
                        m_crc_q   <= 32'h0;
                        busy_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_ready = s_ready_q;
    assign m_valid = m_valid_q;
    assign m_crc   = m_crc_q;
    assign busy    = busy_q;
endmodule

// File: tb/tb_crc32_slice8_ctrl.sv
module tb_crc32_slice8_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [63:0] s_data;
    logic        s_last;
    logic [3:0]  s_nbytes;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_crc;
    logic        busy;

    crc32_slice8_ctrl dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .s_nbytes(s_nbytes),
        .m_valid(m_valid), .m_ready(m_ready), .m_crc(m_crc), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bitwise reference CRC-32 over mbuf[0..len-1].
    logic [7:0] mbuf [0:255];
    function automatic logic [31:0] crc_model(input int len);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < len; i++) begin
            c = c ^ {24'h0, mbuf[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic logic [31:0] model_word(input logic [63:0] d, input int n);
        for (int b = 0; b < 8; b++) mbuf[b] = d[8*b +: 8];
        return crc_model(n);
    endfunction

    typedef struct {
        string       name;
        logic [63:0] data;
        logic [3:0]  nbytes;
        logic [31:0] exp_crc;
        int          exp_lat;
    } vec_t;
    vec_t vecs[8];

    task automatic send(input logic [63:0] d, input logic last, input logic [3:0] nb);
        int g;
        @(negedge clk);
        s_valid = 1'b1; s_data = d; s_last = last; s_nbytes = nb;
        g = 0;
        while (!s_ready && g < 64) begin @(negedge clk); g++; end
        if (g == 64) check("send_ready_timeout", {63'h0, s_ready}, 64'h1);
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_mvalid(output int cyc);
        cyc = 1;
        while (!m_valid && cyc < 64) begin @(posedge clk); #1; cyc++; end
    endtask

    task automatic ack(input string tag);
        @(negedge clk); m_ready = 1'b1;
        @(posedge clk); #1; m_ready = 1'b0;
        check({tag, "_ack_mvalid"}, {63'h0, m_valid}, 64'h0);
        check({tag, "_ack_sready"}, {63'h0, s_ready}, 64'h1);
        check({tag, "_ack_busy"},   {63'h0, busy},    64'h0);
        check({tag, "_ack_mcrc"},   {32'h0, m_crc},   64'h0);
    endtask

    logic        mon_en = 1'b0;
    logic [31:0] mon_q[$];
    always @(negedge clk) if (mon_en && m_valid && m_ready) mon_q.push_back(m_crc);

    initial begin
        int cyc;
        logic [31:0] exp_q[$];
        rst = 1'b1; s_valid = 1'b0; s_data = 64'h0; s_last = 1'b0; s_nbytes = 4'h0; m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sready", {63'h0, s_ready}, 64'h1);
        check("rst_mvalid", {63'h0, m_valid}, 64'h0);
        check("rst_mcrc",   {32'h0, m_crc},   64'h0);
        check("rst_busy",   {63'h0, busy},    64'h0);
        rst = 1'b0;

        vecs[0] = '{"a",      64'h61,               4'd1,  32'hE8B7BE43, 2};
        vecs[1] = '{"abc",    64'h636261,           4'd3,  32'h352441C2, 4};
        vecs[2] = '{"full8",  64'h3837363534333231, 4'd8,  32'h0, 1};
        vecs[3] = '{"nb0",    64'h3837363534333231, 4'd0,  32'h0, 1};
        vecs[4] = '{"nb12",   64'h3837363534333231, 4'd12, 32'h0, 1};
        vecs[5] = '{"nb7",    64'h0123456789ABCDEF, 4'd7,  32'h0, 8};
        vecs[6] = '{"nb5",    64'hDEADBEEFCAFEF00D, 4'd5,  32'h0, 6};
        vecs[7] = '{"nb2",    64'hFFFFFFFFFFFFFF00, 4'd2,  32'h0, 3};
        for (int i = 2; i < 8; i++) vecs[i].exp_crc = model_word(vecs[i].data, vecs[i].exp_lat == 1 ? 8 : vecs[i].exp_lat - 1);

        for (int i = 0; i < 8; i++) begin
            send(vecs[i].data, 1'b1, vecs[i].nbytes);
            wait_mvalid(cyc);
            check({vecs[i].name, "_lat"},    cyc, vecs[i].exp_lat);
            check({vecs[i].name, "_crc"},    {32'h0, m_crc}, {32'h0, vecs[i].exp_crc});
            check({vecs[i].name, "_sready"}, {63'h0, s_ready}, 64'h0);
            check({vecs[i].name, "_busy"},   {63'h0, busy},    64'h1);
            ack(vecs[i].name);
        end

        // "123456789" over two words, then 5 cycles of backpressure.
        send(64'h3837363534333231, 1'b0, 4'd0);
        check("run_busy",   {63'h0, busy},    64'h1);
        check("run_sready", {63'h0, s_ready}, 64'h1);
        check("run_mvalid", {63'h0, m_valid}, 64'h0);
        send(64'h39, 1'b1, 4'd1);
        wait_mvalid(cyc);
        check("c9_lat", cyc, 2);
        check("c9_crc", {32'h0, m_crc}, 64'hCBF43926);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("bp_mvalid", {63'h0, m_valid}, 64'h1);
            check("bp_mcrc",   {32'h0, m_crc},   64'hCBF43926);
            check("bp_sready", {63'h0, s_ready}, 64'h0);
        end
        ack("c9");

        // Reset during the second tail cycle of "abc".
        send(64'h636261, 1'b1, 4'd3);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_mvalid", {63'h0, m_valid}, 64'h0);
        check("midrst_busy",   {63'h0, busy},    64'h0);
        check("midrst_sready", {63'h0, s_ready}, 64'h1);
        check("midrst_mcrc",   {32'h0, m_crc},   64'h0);
        send(64'h61, 1'b1, 4'd1);
        wait_mvalid(cyc);
        check("after_rst_lat", cyc, 2);
        check("after_rst_crc", {32'h0, m_crc}, 64'hE8B7BE43);
        ack("after_rst");

        // Back-to-back random-length messages, s_valid held high.
        m_ready = 1'b1;
        mon_en  = 1'b1;
        for (int m = 0; m < 3; m++) begin
            int len, words;
            len   = $urandom_range(9, 40);
            words = (len + 7) / 8;
            for (int i = 0; i < 256; i++) mbuf[i] = 8'($urandom_range(0, 255));
            exp_q.push_back(crc_model(len));
            for (int w = 0; w < words; w++) begin
                int g;
                logic [63:0] d;
                for (int b = 0; b < 8; b++) d[8*b +: 8] = mbuf[8*w + b];
                @(negedge clk);
                s_valid  = 1'b1;
                s_data   = d;
                s_last   = (w == words - 1);
                s_nbytes = (w == words - 1) ? 4'(len - 8*w) : 4'd0;
                g = 0;
                while (!s_ready && g < 64) begin @(negedge clk); g++; end
                if (w > 0) check("b2b_no_bubble", g, 0);
                else if (g == 64) check("b2b_ready_timeout", {63'h0, s_ready}, 64'h1);
            end
        end
        @(negedge clk);
        s_valid = 1'b0;
        for (int k = 0; k < 200 && mon_q.size() < 3; k++) @(negedge clk);
        check("b2b_count", mon_q.size(), 3);
        for (int m = 0; m < 3; m++) begin
            if (m < mon_q.size()) check("b2b_crc", {32'h0, mon_q[m]}, {32'h0, exp_q[m]});
        end
        mon_en  = 1'b0;
        m_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
